// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_sequencer_pkg : shared op encodings, FSM states and iteration counts
// Revision: 1.0
// ----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [7:0] MD_OP_1H_MUL    = 8'b0000_0001;
  localparam logic [7:0] MD_OP_1H_MULH   = 8'b0000_0010;
  localparam logic [7:0] MD_OP_1H_MULHSU = 8'b0000_0100;
  localparam logic [7:0] MD_OP_1H_MULHU  = 8'b0000_1000;
  localparam logic [7:0] MD_OP_1H_DIV    = 8'b0001_0000;
  localparam logic [7:0] MD_OP_1H_DIVU   = 8'b0010_0000;
  localparam logic [7:0] MD_OP_1H_REM    = 8'b0100_0000;
  localparam logic [7:0] MD_OP_1H_REMU   = 8'b1000_0000;

  localparam int unsigned MD_ITER_64 = 64;
  localparam int unsigned MD_ITER_32 = 32;

  typedef enum logic [1:0] {
    MD_STATE_IDLE  = 2'd0,
    MD_STATE_CALC  = 2'd1,
    MD_STATE_FIXUP = 2'd2,
    MD_STATE_DONE  = 2'd3
  } md_state_e;

  function automatic logic [XLEN-1:0] md_sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_step : one shift-add / restoring-divide iteration on a shared adder
// Revision: 1.0
// ----------------------------------------------------------------------------
module muldiv_step
  import muldiv_sequencer_pkg::*;
(
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   add_x;
  logic [XLEN:0]   add_y;
  logic            add_cin;
  logic [XLEN+1:0] sum;
  logic            no_borrow;

  // Divide subtracts via ~y + 1, so the adder carry-out is the inverted borrow.
  always_comb begin
    if (is_div_i) begin
      add_x   = {hi_i, lo_i[XLEN-1]};
      add_y   = ~{1'b0, opb_i};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, hi_i};
      add_y   = lo_i[0] ? {1'b0, opb_i} : '0;
      add_cin = 1'b0;
    end
  end

  assign sum       = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};
  assign no_borrow = sum[XLEN+1];

  always_comb begin
    if (is_div_i) begin
      hi_o = no_borrow ? sum[XLEN-1:0] : add_x[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], no_borrow};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_sequencer : iterative RV64M multiply/divide controller with stall
// Revision: 1.0
// ----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            squash_i,
  input  logic            start_i,
  input  logic [7:0]      op_1h_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_ao,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [5:0] LAST_64 = 6'(MD_ITER_64 - 1);
  localparam logic [5:0] LAST_32 = 6'(MD_ITER_32 - 1);

  md_state_e       state_q, state_d;
  logic [7:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;
  logic            special_q, special_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_quot, in_rem, in_divop, a_signed, b_signed;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic            a_neg, b_neg, div_zero, div_ovf, in_special, in_neg;
  logic [XLEN-1:0] spec_val;

  // Operand conditioning for the op being offered by dispatch.
  always_comb begin
    in_quot  = |(op_1h_i & (MD_OP_1H_DIV | MD_OP_1H_DIVU));
    in_rem   = |(op_1h_i & (MD_OP_1H_REM | MD_OP_1H_REMU));
    in_divop = in_quot | in_rem;
    a_signed = |(op_1h_i & (MD_OP_1H_MULH | MD_OP_1H_MULHSU | MD_OP_1H_DIV | MD_OP_1H_REM));
    b_signed = |(op_1h_i & (MD_OP_1H_MULH | MD_OP_1H_DIV | MD_OP_1H_REM));
    a_ext    = a_i;
    b_ext    = b_i;
    if (word_i) begin
      a_ext = a_signed ? md_sext32(a_i[31:0]) : {32'd0, a_i[31:0]};
      b_ext = b_signed ? md_sext32(b_i[31:0]) : {32'd0, b_i[31:0]};
    end
    a_neg    = a_signed & a_ext[XLEN-1];
    b_neg    = b_signed & b_ext[XLEN-1];
    a_abs    = a_neg ? (~a_ext + 64'd1) : a_ext;
    b_abs    = b_neg ? (~b_ext + 64'd1) : b_ext;
    div_zero = (b_ext == '0);
    div_ovf  = |(op_1h_i & (MD_OP_1H_DIV | MD_OP_1H_REM)) && (b_ext == '1) &&
               (a_ext == (word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    in_special = in_divop & (div_zero | div_ovf);

    if (div_zero) begin
      spec_val = in_quot ? '1 : (word_i ? md_sext32(a_i[31:0]) : a_i);
    end else begin
      spec_val = in_quot ? a_ext : '0;
    end

    in_neg = 1'b0;
    if (|(op_1h_i & (MD_OP_1H_MULH | MD_OP_1H_DIV))) begin
      in_neg = a_neg ^ b_neg;
    end else if (|(op_1h_i & (MD_OP_1H_MULHSU | MD_OP_1H_REM))) begin
      in_neg = a_neg;
    end
  end

  logic [XLEN-1:0] step_hi, step_lo;

  muldiv_step u_step (
    .is_div_i (|op_q[7:4]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opb_i    (opb_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  logic [XLEN-1:0] sel_val, sel_neg, fix_val;

  // Word divides leave the quotient in lo[31:0] and remainder in hi[31:0].
  always_comb begin
    sel_val = (|op_q[5:4]) ? lo_q : hi_q;
    sel_neg = neg_q ? (~sel_val + 64'd1) : sel_val;
    if (special_q) begin
      fix_val = lo_q;
    end else if (op_q[0]) begin
      fix_val = word_q ? md_sext32(lo_q[63:32]) : lo_q;
    end else if (|op_q[3:1]) begin
      fix_val = neg_q ? (~hi_q + {63'd0, lo_q == '0}) : hi_q;
    end else begin
      fix_val = word_q ? md_sext32(sel_neg[31:0]) : sel_neg;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    neg_d     = neg_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      MD_STATE_IDLE: begin
        if (start_i && !squash_i) begin
          op_d      = op_1h_i;
          word_d    = word_i;
          neg_d     = in_neg;
          special_d = in_special;
          cnt_d     = '0;
          hi_d      = '0;
          opb_d     = b_abs;
          if (in_special) begin
            lo_d = spec_val;
          end else if (in_divop && word_i) begin
            lo_d = {a_abs[31:0], 32'd0};
          end else begin
            lo_d = a_abs;
          end
          state_d = in_special ? MD_STATE_FIXUP : MD_STATE_CALC;
        end
      end
      MD_STATE_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == (word_q ? LAST_32 : LAST_64)) begin
          state_d = MD_STATE_FIXUP;
        end
      end
      MD_STATE_FIXUP: begin
        result_d = fix_val;
        done_d   = 1'b1;
        state_d  = MD_STATE_DONE;
      end
      MD_STATE_DONE: begin
        state_d = MD_STATE_IDLE;
      end
      default: begin
        state_d = MD_STATE_IDLE;
      end
    endcase

    if (squash_i) begin
      state_d  = MD_STATE_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= MD_STATE_IDLE;
      op_q      <= '0;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      word_q    <= word_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy_ao  = ((state_q == MD_STATE_IDLE) & start_i & ~squash_i) |
                    (state_q == MD_STATE_CALC) | (state_q == MD_STATE_FIXUP);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_sequencer : directed + random checks against an arithmetic model
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_sequencer;

  logic        clk_i    = 1'b0;
  logic        rst_ni   = 1'b0;
  logic        squash_i = 1'b0;
  logic        start_i  = 1'b0;
  logic [7:0]  op_1h_i  = '0;
  logic        word_i   = 1'b0;
  logic [63:0] a_i      = '0;
  logic [63:0] b_i      = '0;
  logic        busy_ao;
  logic        done_o;
  logic [63:0] result_o;

  int          checks   = 0;
  int          errors   = 0;
  logic [63:0] last_exp = '0;

  localparam int OP_MUL = 0, OP_MULH = 1, OP_MULHSU = 2, OP_MULHU = 3;
  localparam int OP_DIV = 4, OP_DIVU = 5, OP_REM = 6, OP_REMU = 7;

  always #5 clk_i = ~clk_i;

  muldiv_sequencer dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .squash_i (squash_i),
    .start_i  (start_i),
    .op_1h_i  (op_1h_i),
    .word_i   (word_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_ao  (busy_ao),
    .done_o   (done_o),
    .result_o (result_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural result of an RV64M op, from plain wide arithmetic.
  function automatic logic [63:0] ref_model(input int op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0]        ua32, ub32;
    logic               ovf64, ovf32;
    sa    = a;
    sb    = b;
    sa32  = a[31:0];
    sb32  = b[31:0];
    ua32  = a[31:0];
    ub32  = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
    case (op)
      OP_MUL: begin
        p = {64'd0, a} * {64'd0, b};
        return w ? sx(p[31:0]) : p[63:0];
      end
      OP_MULH: begin
        p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        return p[127:64];
      end
      OP_MULHSU: begin
        p = {{64{a[63]}}, a} * {64'd0, b};
        return p[127:64];
      end
      OP_MULHU: begin
        p = {64'd0, a} * {64'd0, b};
        return p[127:64];
      end
      OP_DIV: begin
        if (w) return (ub32 == 0) ? '1 : ovf32 ? sx(ua32) : sx(32'(sa32 / sb32));
        return (b == 0) ? '1 : ovf64 ? a : 64'(sa / sb);
      end
      OP_DIVU: begin
        if (w) return (ub32 == 0) ? '1 : sx(ua32 / ub32);
        return (b == 0) ? '1 : a / b;
      end
      OP_REM: begin
        if (w) return (ub32 == 0) ? sx(ua32) : ovf32 ? '0 : sx(32'(sa32 % sb32));
        return (b == 0) ? a : ovf64 ? '0 : 64'(sa % sb);
      end
      OP_REMU: begin
        if (w) return (ub32 == 0) ? sx(ua32) : sx(ua32 % ub32);
        return (b == 0) ? a : a % b;
      end
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input int op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
             : (a == 64'h8000_0000_0000_0000 && b == '1);
    if (op >= OP_DIV && (zero || ((op == OP_DIV || op == OP_REM) && ovf))) return 2;
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 20));
      4:       return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one op right after a rising edge and follow it to its done pulse.
  task automatic run_op(input int op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input string tag);
    logic [63:0] exp;
    int          lat, cyc, busy_bad;
    logic        seen;
    exp = ref_model(op, w, a, b);
    lat = ref_latency(op, w, a, b);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    op_1h_i = 8'(1 << op);
    word_i  = w;
    a_i     = a;
    b_i     = b;
    @(negedge clk_i);
    check({tag, " busy@accept"}, 64'(busy_ao), 64'd1);
    check({tag, " done low@accept"}, 64'(done_o), 64'd0);
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    a_i      = {$urandom, $urandom};
    b_i      = {$urandom, $urandom};
    cyc      = 1;
    seen     = 1'b0;
    busy_bad = 0;
    while (!seen && cyc <= 100) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (!busy_ao) busy_bad++;
        cyc++;
      end
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " busy during op"}, 64'(busy_bad), 64'd0);
    check({tag, " busy@done"}, 64'(busy_ao), 64'd0);
    check({tag, " result"}, result_o, exp);
    last_exp = exp;
  endtask

  initial begin
    int done_cnt;
    #1;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset busy", 64'(busy_ao), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    check("reset result", result_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op(OP_MUL,   1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "MUL 7*-3");
    run_op(OP_MULHU, 1'b0, '1, '1, "MULHU ones");
    run_op(OP_MULH,  1'b0, '1, '1, "MULH ones");
    run_op(OP_DIVU,  1'b0, 64'd5, 64'd0, "DIVU 5/0");
    run_op(OP_REM,   1'b0, 64'd5, 64'd0, "REM 5/0");
    run_op(OP_DIV,   1'b0, 64'h8000_0000_0000_0000, '1, "DIV ovf");
    run_op(OP_REM,   1'b0, 64'h8000_0000_0000_0000, '1, "REM ovf");
    run_op(OP_DIV,   1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, "DIVW -7/2");
    run_op(OP_REM,   1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, "REMW -7/2");
    run_op(OP_DIVU,  1'b1, 64'hDEAD_BEEF_8000_0001, 64'd0, "DIVUW x/0");
    run_op(OP_REMU,  1'b1, 64'h1234_5678_8000_0001, 64'd0, "REMUW x/0");

    // Squash a DIV in its 20th cycle after acceptance.
    @(posedge clk_i); #1;
    start_i = 1'b1;
    op_1h_i = 8'(1 << OP_DIV);
    word_i  = 1'b0;
    a_i     = 64'd1000;
    b_i     = 64'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk_i);
    #1;
    squash_i = 1'b1;
    @(posedge clk_i); #1;
    squash_i = 1'b0;
    @(negedge clk_i);
    check("squash busy", 64'(busy_ao), 64'd0);
    check("squash done", 64'(done_o), 64'd0);
    check("squash result held", result_o, last_exp);
    done_cnt = 0;
    repeat (70) begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
    end
    check("squash no done", 64'(done_cnt), 64'd0);
    check("squash result still held", result_o, last_exp);
    run_op(OP_MUL, 1'b0, 64'd6, 64'd7, "MUL 6*7 after squash");

    // Asynchronous reset in the middle of a MUL.
    @(posedge clk_i); #1;
    start_i = 1'b1;
    op_1h_i = 8'(1 << OP_MUL);
    word_i  = 1'b0;
    a_i     = 64'd123456;
    b_i     = 64'd789;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async reset result", result_o, 64'd0);
    check("async reset done", 64'(done_o), 64'd0);
    check("async reset busy", 64'(busy_ao), 64'd0);
    repeat (3) @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    done_cnt = 0;
    repeat (80) begin
      @(negedge clk_i);
      if (done_o) done_cnt++;
    end
    check("no done after reset", 64'(done_cnt), 64'd0);
    run_op(OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, "MULHSU after reset");

    for (int i = 0; i < 40; i++) begin
      int          op;
      logic        w;
      logic [63:0] a, b;
      op = int'($urandom_range(0, 7));
      w  = (op == OP_MUL || op >= OP_DIV) ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, w, a, b, $sformatf("rand%0d op%0d w%0d", i, op, w));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
